// File: rtl/base64_stream_encoder_if.sv
// Stream bundle for the Base64 encoder: byte beats in, ASCII beats out.
// Each side transfers when valid && ready are both high at a rising clk edge.
interface base64_stream_encoder_if #(
  parameter int GROUPS = 20
);
  localparam int IW = 24 * GROUPS;
  localparam int OW = 32 * GROUPS;
  localparam int BW = $clog2(3 * GROUPS + 1);
  localparam int CW = $clog2(4 * GROUPS + 1);

  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] in_data;
  logic          in_last;
  logic [BW-1:0] in_bytes;
  logic          url_safe;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic [CW-1:0] out_chars;

  modport master (
    output in_valid, in_data, in_last, in_bytes, url_safe, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_chars
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, url_safe, out_ready,
    output in_ready, out_valid, out_data, out_last, out_chars
  );
endinterface

// File: rtl/base64_stream_encoder.sv
// Two-stage streaming Base64 encoder: S1 captures a beat, S2 holds the ASCII
// result. Supports partial last beats, '=' padding and a URL-safe alphabet.
module base64_stream_encoder #(
  parameter int GROUPS = 20,
  parameter bit PAD_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  base64_stream_encoder_if.slave     bus,
  output logic [CNT_W-1:0]           frame_cnt
);
  localparam int IW = 24 * GROUPS;
  localparam int OW = 32 * GROUPS;
  localparam int NB = 3 * GROUPS;
  localparam int BW = $clog2(3 * GROUPS + 1);
  localparam int CW = $clog2(4 * GROUPS + 1);

  logic          adv1, adv2;
  logic          s1_valid, s1_url, s1_last;
  logic [IW-1:0] s1_data;
  logic [BW-1:0] s1_n, n_eff;
  logic          s2_valid, s2_last;
  logic [OW-1:0] s2_data, enc;
  logic [CW-1:0] s2_chars, enc_chars;

  function automatic logic [7:0] b64_char(input logic [5:0] idx, input logic url);
    logic [7:0] ch;
    if (idx < 6'd26)       ch = 8'h41 + {2'b00, idx};
    else if (idx < 6'd52)  ch = 8'h61 + {2'b00, idx} - 8'd26;
    else if (idx < 6'd62)  ch = 8'h30 + {2'b00, idx} - 8'd52;
    else if (idx == 6'd62) ch = url ? 8'h2D : 8'h2B;
    else                   ch = url ? 8'h5F : 8'h2F;
    return ch;
  endfunction

  assign adv2 = !s2_valid || bus.out_ready;
  assign adv1 = !s1_valid || adv2;

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_last  = s2_last;
  assign bus.out_chars = s2_chars;

  // Oversized byte counts are clamped to a full beat.
  always_comb begin
    n_eff = BW'(NB);
    if (bus.in_last && bus.in_bytes != '0)
      n_eff = (int'(bus.in_bytes) > NB) ? BW'(NB) : bus.in_bytes;
  end

  always_comb begin : enc_p
    logic [IW-1:0] masked;
    logic [23:0]   word;
    int            avail;
    masked = '0;
    word   = '0;
    avail  = 0;
    enc    = '0;
    // Bytes past n are zeroed so they cannot leak into the last group's bits.
    for (int b = 0; b < NB; b++)
      if (b < int'(s1_n)) masked[IW-1-8*b -: 8] = s1_data[IW-1-8*b -: 8];
    for (int g = 0; g < GROUPS; g++) begin
      word  = masked[IW-1-24*g -: 24];
      avail = int'(s1_n) - 3 * g;
      if (avail > 0) begin
        for (int c = 0; c < 4; c++) begin
          if (c <= avail) enc[OW-1-32*g-8*c -: 8] = b64_char(word[23-6*c -: 6], s1_url);
          else            enc[OW-1-32*g-8*c -: 8] = PAD_EN ? 8'h3D : 8'h00;
        end
      end
    end
  end

  always_comb begin : chars_p
    int n, q, r;
    n = int'(s1_n);
    q = n / 3;
    r = n % 3;
    if (PAD_EN) enc_chars = CW'(4 * q + ((r != 0) ? 4 : 0));
    else        enc_chars = CW'(4 * q + ((r != 0) ? r + 1 : 0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_last   <= 1'b0;
      s2_chars  <= '0;
      frame_cnt <= '0;
    end else begin
      if (adv1) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_data <= bus.in_data;
          s1_url  <= bus.url_safe;
          s1_last <= bus.in_last;
          s1_n    <= n_eff;
        end
      end
      if (adv2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_data  <= enc;
          s2_last  <= s1_last;
          s2_chars <= enc_chars;
        end
      end
      if (s2_valid && bus.out_ready && s2_last) frame_cnt <= frame_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_base64_stream_encoder.sv
// Bench for base64_stream_encoder: two GROUPS=1 instances (padded / unpadded,
// 3-bit frame counter) share stimulus; a GROUPS=20 instance covers wide beats.
module tb_base64_stream_encoder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  base64_stream_encoder_if #(.GROUPS(1))  b1 ();
  base64_stream_encoder_if #(.GROUPS(1))  b0 ();
  base64_stream_encoder_if #(.GROUPS(20)) b20 ();
  logic [15:0] fc1, fc20;
  logic [2:0]  fc0;

  base64_stream_encoder #(.GROUPS(1),  .PAD_EN(1'b1), .CNT_W(16)) u1  (.clk(clk), .rst(rst), .bus(b1),  .frame_cnt(fc1));
  base64_stream_encoder #(.GROUPS(1),  .PAD_EN(1'b0), .CNT_W(3))  u0  (.clk(clk), .rst(rst), .bus(b0),  .frame_cnt(fc0));
  base64_stream_encoder #(.GROUPS(20), .PAD_EN(1'b1), .CNT_W(16)) u20 (.clk(clk), .rst(rst), .bus(b20), .frame_cnt(fc20));

  int checks = 0, failures = 0;
  logic [35:0]  exp1_q[$], exp0_q[$];
  logic [647:0] exp20_q[$];
  int exp_f1 = 0, exp_f0 = 0, exp_f20 = 0;
  bit stall1 = 0, stall20 = 0, rnd_rdy = 0;
  logic [36:0]  held1;
  logic [648:0] held20;

  typedef struct {
    logic [23:0] d; bit last; logic [1:0] nb; bit url;
    logic [31:0] e1; logic [2:0] c1; logic [31:0] e0; logic [2:0] c0;
  } vec_t;
  vec_t tbl[10];

  task automatic check(input string name, input logic [648:0] act, input logic [648:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: encode the byte string three bytes at a time, then lay the characters out.
  function automatic logic [647:0] model(input logic [479:0] d, input int g, input bit last,
                                          input int nb, input bit url, input bit pad);
    string alpha;
    logic [7:0] ch[$];
    logic [639:0] data;
    int n, chars, left, v;
    alpha = url ? "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789-_"
                : "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
    n = (last && nb != 0) ? ((nb > 3 * g) ? 3 * g : nb) : 3 * g;
    chars = 0;
    data = '0;
    for (int i = 0; i < n; i += 3) begin
      left = n - i;
      v = 0;
      for (int k = 0; k < 3; k++) begin
        v = v << 8;
        if (k < left) v = v | int'(d[24*g-1-8*(i+k) -: 8]);
      end
      for (int k = 0; k < 4; k++) begin
        if (k <= left) begin
          ch.push_back(alpha[(v >> (18 - 6 * k)) & 63]);
          chars++;
        end else begin
          ch.push_back(pad ? 8'h3D : 8'h00);
          if (pad) chars++;
        end
      end
    end
    for (int k = 0; k < ch.size(); k++) data[32*g-1-8*k -: 8] = ch[k];
    return {last, 7'(chars), data};
  endfunction

  function automatic logic [35:0] to1(input logic [647:0] e);
    return {e[647], e[642:640], e[31:0]};
  endfunction

  // Scoreboards: compare each accepted output beat, and check held beats stay put.
  always @(negedge clk) begin
    if (rst) stall1 = 0;
    else begin
      if (stall1) check("hold1", {b1.out_valid, b1.out_last, b1.out_chars, b1.out_data}, held1);
      if (b1.out_valid && b1.out_ready) begin
        if (exp1_q.size() == 0) check("beat1_unexpected", 1, 0);
        else check("beat1", {b1.out_last, b1.out_chars, b1.out_data}, exp1_q.pop_front());
        if (b1.out_last) exp_f1++;
      end
      stall1 = b1.out_valid && !b1.out_ready;
      held1  = {b1.out_valid, b1.out_last, b1.out_chars, b1.out_data};
    end
  end

  always @(negedge clk) begin
    if (!rst && b0.out_valid && b0.out_ready) begin
      if (exp0_q.size() == 0) check("beat0_unexpected", 1, 0);
      else check("beat0", {b0.out_last, b0.out_chars, b0.out_data}, exp0_q.pop_front());
      if (b0.out_last) exp_f0++;
    end
  end

  always @(negedge clk) begin
    if (rst) stall20 = 0;
    else begin
      if (stall20) check("hold20", {b20.out_valid, b20.out_last, b20.out_chars, b20.out_data}, held20);
      if (b20.out_valid && b20.out_ready) begin
        if (exp20_q.size() == 0) check("beat20_unexpected", 1, 0);
        else check("beat20", {b20.out_last, b20.out_chars, b20.out_data}, exp20_q.pop_front());
        if (b20.out_last) exp_f20++;
      end
      stall20 = b20.out_valid && !b20.out_ready;
      held20  = {b20.out_valid, b20.out_last, b20.out_chars, b20.out_data};
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) begin
      b1.out_ready  = ($urandom_range(0, 3) != 0);
      b0.out_ready  = b1.out_ready;
      b20.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send1(input logic [23:0] d, input bit last, input logic [1:0] nb, input bit url,
                       input logic [35:0] e1, input logic [35:0] e0);
    bit acc = 0;
    b1.in_data = d;  b1.in_last = last; b1.in_bytes = nb; b1.url_safe = url; b1.in_valid = 1;
    b0.in_data = d;  b0.in_last = last; b0.in_bytes = nb; b0.url_safe = url; b0.in_valid = 1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk); acc = b1.in_ready;
      @(posedge clk); #1;
    end
    b1.in_valid = 0; b0.in_valid = 0;
    if (!acc) check("send1_timeout", 0, 1);
    else begin exp1_q.push_back(e1); exp0_q.push_back(e0); end
  endtask

  task automatic send1m(input logic [23:0] d, input bit last, input logic [1:0] nb, input bit url);
    send1(d, last, nb, url, to1(model({456'b0, d}, 1, last, int'(nb), url, 1)),
                            to1(model({456'b0, d}, 1, last, int'(nb), url, 0)));
  endtask

  task automatic send20(input logic [479:0] d, input bit last, input logic [5:0] nb, input bit url,
                        output int waited);
    bit acc = 0;
    waited = -1;
    b20.in_data = d; b20.in_last = last; b20.in_bytes = nb; b20.url_safe = url; b20.in_valid = 1;
    for (int t = 0; t < 200 && !acc; t++) begin
      @(negedge clk); acc = b20.in_ready;
      @(posedge clk); #1;
      waited++;
    end
    b20.in_valid = 0;
    if (!acc) check("send20_timeout", 0, 1);
    else exp20_q.push_back(model(d, 20, last, int'(nb), url, 1));
  endtask

  function automatic logic [479:0] rand480();
    logic [479:0] r;
    for (int w = 0; w < 15; w++) r[32*w +: 32] = $urandom;
    return r;
  endfunction

  task automatic drain();
    bit done = 0;
    rnd_rdy = 0;
    b1.out_ready = 1; b0.out_ready = 1; b20.out_ready = 1;
    for (int t = 0; t < 400 && !done; t++) begin
      @(negedge clk);
      done = (exp1_q.size() == 0 && exp0_q.size() == 0 && exp20_q.size() == 0);
    end
    @(posedge clk); #1;
    if (!done) check("drain_timeout", 0, 1);
  endtask

  initial begin
    int waited, n_acc;
    logic [479:0] cur;
    tbl[0] = '{24'h4D616E, 1, 2'd3, 0, 32'h54574675, 3'd4, 32'h54574675, 3'd4};
    tbl[1] = '{24'h4D6100, 1, 2'd2, 0, 32'h5457453D, 3'd4, 32'h54574500, 3'd3};
    tbl[2] = '{24'h4D0000, 1, 2'd1, 0, 32'h54513D3D, 3'd4, 32'h54510000, 3'd2};
    tbl[3] = '{24'hFBFF00, 1, 2'd2, 0, 32'h2B2F383D, 3'd4, 32'h2B2F3800, 3'd3};
    tbl[4] = '{24'hFBFF00, 1, 2'd2, 1, 32'h2D5F383D, 3'd4, 32'h2D5F3800, 3'd3};
    tbl[5] = '{24'h4DFFFF, 1, 2'd1, 0, 32'h54513D3D, 3'd4, 32'h54510000, 3'd2};
    tbl[6] = '{24'h4D616E, 1, 2'd0, 0, 32'h54574675, 3'd4, 32'h54574675, 3'd4};
    tbl[7] = '{24'h000000, 1, 2'd3, 0, 32'h41414141, 3'd4, 32'h41414141, 3'd4};
    tbl[8] = '{24'h4D616E, 0, 2'd1, 0, 32'h54574675, 3'd4, 32'h54574675, 3'd4};
    tbl[9] = '{24'hFBFFFF, 1, 2'd3, 1, 32'h2D5F5F5F, 3'd4, 32'h2D5F5F5F, 3'd4};

    // Clock/reset
    rst = 1;
    b1.in_valid = 0; b0.in_valid = 0; b20.in_valid = 0;
    b1.out_ready = 1; b0.out_ready = 1; b20.out_ready = 1;
    b1.in_data = '0; b1.in_last = 0; b1.in_bytes = '0; b1.url_safe = 0;
    b0.in_data = '0; b0.in_last = 0; b0.in_bytes = '0; b0.url_safe = 0;
    b20.in_data = '0; b20.in_last = 0; b20.in_bytes = '0; b20.url_safe = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_state1", {b1.out_valid, b1.out_data, b1.out_last, b1.out_chars, b1.in_ready, fc1},
          {1'b0, 32'h0, 1'b0, 3'd0, 1'b1, 16'h0});
    check("rst_state20", {b20.out_valid, b20.out_data, b20.out_last, b20.out_chars, b20.in_ready, fc20},
          {1'b0, 640'h0, 1'b0, 7'd0, 1'b1, 16'h0});
    @(posedge clk); #1;

    // "Man": out_valid appears two cycles after acceptance, then one frame counted.
    b1.in_data = 24'h4D616E; b1.in_last = 1; b1.in_bytes = 2'd3; b1.url_safe = 0; b1.in_valid = 1;
    b0.in_data = 24'h4D616E; b0.in_last = 1; b0.in_bytes = 2'd3; b0.url_safe = 0; b0.in_valid = 1;
    @(negedge clk); check("lat_in_ready", b1.in_ready, 1);
    @(posedge clk); #1;
    b1.in_valid = 0; b0.in_valid = 0;
    exp1_q.push_back({1'b1, 3'd4, 32'h54574675});
    exp0_q.push_back({1'b1, 3'd4, 32'h54574675});
    @(negedge clk); check("lat_cycle1", b1.out_valid, 0);
    @(negedge clk); check("lat_cycle2", b1.out_valid, 1);
    @(negedge clk); check("frames_after_man", fc1, 16'd1);
    @(posedge clk); #1;

    // Table vectors, back to back
    foreach (tbl[i])
      send1(tbl[i].d, tbl[i].last, tbl[i].nb, tbl[i].url,
            {tbl[i].last, tbl[i].c1, tbl[i].e1}, {tbl[i].last, tbl[i].c0, tbl[i].e0});
    drain();
    check("frames1_table", fc1, 16'd10);
    check("frames0_wrap", fc0, 3'd2);

    // Random GROUPS=1 traffic with random back-pressure
    rnd_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      send1m(24'($urandom), $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    drain();
    check("frames1_rand", fc1, 16'(exp_f1));
    check("frames0_rand", fc0, 3'(exp_f0 % 8));

    // GROUPS=20: ten back-to-back full beats must each be taken on the first try
    for (int i = 0; i < 10; i++) begin
      send20(rand480(), 0, 6'd0, 1'($urandom_range(0, 1)), waited);
      check("b2b_no_wait", waited, 0);
    end
    send20(rand480(), 1, 6'd7, 0, waited);
    drain();
    check("frames20_partial", fc20, 16'd1);

    // Stall: with out_ready low only two beats fit into the pipeline
    b20.out_ready = 0;
    n_acc = 0;
    cur = rand480();
    for (int c = 0; c < 5; c++) begin
      b20.in_data = cur; b20.in_last = 0; b20.in_bytes = '0; b20.url_safe = 1; b20.in_valid = 1;
      @(negedge clk);
      if (b20.in_ready) begin
        n_acc++;
        @(posedge clk); #1;
        exp20_q.push_back(model(cur, 20, 0, 0, 1, 1));
        cur = rand480();
      end else begin
        @(posedge clk); #1;
      end
    end
    b20.in_valid = 0;
    check("stall_accepted", n_acc, 2);
    @(negedge clk); check("stall_in_ready", b20.in_ready, 0);
    @(posedge clk); #1;
    drain();

    // Random GROUPS=20 frames, including oversized byte counts
    rnd_rdy = 1;
    for (int i = 0; i < 80; i++) begin
      send20(rand480(), $urandom_range(0, 3) == 0, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), waited);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    drain();
    check("frames20_rand", fc20, 16'(exp_f20));

    // Reset with both stages full discards the in-flight beats
    b20.out_ready = 0;
    send20(rand480(), 0, 6'd0, 0, waited);
    send20(rand480(), 1, 6'd5, 0, waited);
    rst = 1;
    exp20_q.delete(); exp1_q.delete(); exp0_q.delete();
    exp_f1 = 0; exp_f0 = 0; exp_f20 = 0;
    @(posedge clk); #1;
    rst = 0;
    b20.out_ready = 1;
    @(negedge clk);
    check("rst_mid_out_valid", b20.out_valid, 0);
    check("rst_mid_frames20", fc20, 16'd0);
    check("rst_mid_frames1", fc1, 16'd0);
    check("rst_mid_in_ready", b20.in_ready, 1);
    @(posedge clk); #1;
    send20(rand480(), 1, 6'd40, 1, waited);
    drain();
    check("frames20_after_rst", fc20, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/base64_stream_encoder.md
Name: base64_stream_encoder

Overview:
Streaming, parametrised Base64 encoder that replaces the fixed 480-bit-to-640-bit table-lookup encoder.
- Accepts GROUPS×3 bytes per beat over a valid/ready handshake and emits GROUPS×4 ASCII characters per beat through a 2-stage pipeline.
- Adds support for frames whose last beat is partial, RFC 4648 '=' padding, a runtime URL-safe alphabet, and back-pressure.
- Sits between the packet payload buffer and the transmit framer.

Parameters:
GROUPS, 20, number of 3-byte groups per beat (input 24·GROUPS bits, output 32·GROUPS bits); legal range 1..64
PAD_EN, 1, 1: pad partial groups with '=' (0x3D); 0: leave unused character slots as 0x00
CNT_W, 16, width of the frame counter

Ports:
clk  in  1  clock
rst  in  1  reset; one clock, reset is synchronous and active-high
in_valid  in  1  input beat valid
in_ready  out  1  encoder can accept a beat
in_data  in  24·GROUPS  payload; byte 0 in [24·GROUPS-1 -: 8], MSB-first
in_last  in  1  beat is the last beat of its frame
in_bytes  in  $clog2(3·GROUPS+1)  valid bytes in the beat, read only when in_last=1; 0 means full beat
url_safe  in  1  per-beat alphabet select: 0 standard (+,/), 1 URL-safe (-,_)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_data  out  32·GROUPS  ASCII characters; char 0 in [32·GROUPS-1 -: 8]
out_last  out  1  copy of in_last for this beat
out_chars  out  $clog2(4·GROUPS+1)  meaningful characters in out_data, padding included
frame_cnt  out  CNT_W  number of completed frames (out_last beats accepted downstream)

Behaviour:
- Reset: rst=1 at a rising edge clears both pipeline valids and frame_cnt.
  - Next cycle: out_valid=0, out_data=0, out_last=0, out_chars=0, frame_cnt=0, in_ready=1.
  - Reset in the middle of a frame discards any beats in flight; no partial output is emitted afterwards.
- Handshake: a transfer occurs when valid&&ready on the same edge.
  - out_data, out_last and out_chars stay stable while out_valid && !out_ready.
  - in_ready does not depend combinationally on in_valid.
- Pipeline: S1 registers in_data, url_safe, in_last and the effective byte count n (n=3·GROUPS unless in_last && in_bytes≠0). S2 registers the ASCII result.
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || (s1_valid && adv2)
  - in_ready = adv1
  - Latency: 2 cycles from input acceptance to out_valid, with no stall.
  - Throughput: 1 beat per cycle under continuous out_ready.
- Encoding: group g covers bytes 3g..3g+2. Its 24 bits are split MSB-first into four 6-bit indices, each mapped as follows:
  - 0-25 → 'A'-'Z'
  - 26-51 → 'a'-'z'
  - 52-61 → '0'-'9'
  - 62 → '+' (or '-' when url_safe)
  - 63 → '/' (or '_' when url_safe)
- Partial beat, with q=floor(n/3) and r=n mod 3:
  - Groups below q encode normally.
  - r=1: group q encodes byte 3q with missing bytes taken as zero. It produces 2 characters, then "==" if PAD_EN, else 0x00 0x00.
  - r=2: it produces 3 characters, then "=" if PAD_EN, else 0x00.
  - Groups beyond q (or beyond q+1 when r≠0) output 0x00 in every character slot.
  - Input bytes past n are ignored, whatever their value.
  - out_chars = 4·ceil(n/3) when PAD_EN=1, else 4q + (r==0 ? 0 : r+1).
- Non-last beats always have n=3·GROUPS, so out_chars=4·GROUPS.
- frame_cnt increments by 1 on every out_valid && out_ready && out_last. It wraps from 2^CNT_W−1 to 0.
- in_bytes > 3·GROUPS is illegal. The encoder clamps it to 3·GROUPS.

Test Plan:
1. GROUPS=1, PAD_EN=1: "Man" (0x4D616E), last, in_bytes=3 → out_data "TWFu" (0x5457_4675), out_chars=4, out_last=1 two cycles after acceptance, frame_cnt=1.
2. GROUPS=1: "Ma" in_bytes=2 → "TWE=" (0x5457_453D), out_chars=4. "M" in_bytes=1 → "TQ==". Repeat with PAD_EN=0 → "TWE\0", out_chars=3, and "TQ\0\0", out_chars=2.
3. GROUPS=1, in_data=0xFBFF00, in_bytes=2, last → url_safe=0 gives "+/8=", url_safe=1 gives "-_8=".
4. GROUPS=20: 10 back-to-back full beats with out_ready=1 → 10 consecutive output beats, in_ready stays 1, and each beat matches the software model. Then hold out_ready=0 for 5 cycles → in_ready falls after 2 more beats are accepted, out_data holds stable, and no beat is lost or duplicated on release.
5. GROUPS=20, last beat in_bytes=7 → groups 0-1 full, group 2 "xx==", groups 3-19 all 0x00, out_chars=12.
6. Assert rst for 1 cycle with both stages full → out_valid=0, frame_cnt=0 next cycle, and the following frame encodes correctly with no stale beats.
